// File: rtl/preio_pkg.sv
// Shared types and constants for the pre-IO serial lane (transmit and receive sides).
package preio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    GAP
  } state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;

  // Cycles a frame occupies the lane, counted from the accept edge.
  function automatic int unsigned frame_cycles(input int unsigned dw, input int unsigned gap_cyc);
    return 2 + dw + gap_cyc;
  endfunction

endpackage

// File: rtl/preio_serial_arbiter_if.sv
// Requester-side handshake bundle: per-requester valid/data in, one-hot ready out.
interface preio_serial_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);

  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic [NREQ-1:0]    REQ_READY;

  modport master (output REQ_VALID, REQ_DATA, input REQ_READY);
  modport slave  (input REQ_VALID, REQ_DATA, output REQ_READY);

endinterface

// File: rtl/preio_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping upward.
module preio_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Scan NREQ positions starting at ptr; the first valid one wins.
  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && valid[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/preio_serial_arbiter.sv
// Round-robin share of one pre-IO output lane: accept a word, send start/data/parity/gap.
module preio_serial_arbiter
  import preio_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int DW      = 8,
  parameter  int GAP_CYC = 2,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic                   FPGA_CLK,
  input  logic                   FPGA_RST_N,
  input  logic                   ENABLE,
  preio_serial_arbiter_if.slave  req,
  output logic                   PREIO_OUT,
  output logic                   PREIO_CLK_EN,
  output logic                   BUSY,
  output logic [GW-1:0]          GNT_ID
);

  localparam int BW  = $clog2(DW + 1);
  localparam int GCW = $clog2(GAP_CYC + 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            par_q, par_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt_id_d;
  logic            lane_d, clk_en_d, busy_d;

  logic [NREQ-1:0] gnt;
  logic [GW-1:0]   win_idx;
  logic            any_valid;
  logic            accept;
  logic [DW-1:0]   win_word;

  preio_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid (req.REQ_VALID),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .idx   (win_idx),
    .any   (any_valid)
  );

  // Ready is only offered from IDLE with new grants enabled, and never while reset is held.
  assign accept        = (state_q == IDLE) && ENABLE && FPGA_RST_N && any_valid;
  assign req.REQ_READY = accept ? gnt : '0;
  assign win_word      = req.REQ_DATA[win_idx*DW +: DW];

  // Next-state and next-output logic; lane values are set on the edge entering each state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ptr_d     = ptr_q;
    gnt_id_d  = GNT_ID;
    lane_d    = IDLE_LVL;
    clk_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d  = win_word;
          par_d    = ^win_word;
          gnt_id_d = win_idx;
          ptr_d    = (win_idx == GW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d  = START;
          lane_d   = START_LVL;
          clk_en_d = 1'b1;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = BW'(DW);
        lane_d    = shift_q[0];
        shift_d   = shift_q >> 1;
        clk_en_d  = 1'b1;
      end
      DATA: begin
        clk_en_d = 1'b1;
        // bit_cnt holds the bits still on the lane, including the one showing now.
        if (bit_cnt_q == BW'(1)) begin
          state_d = PARITY;
          lane_d  = par_q;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          lane_d    = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d   = GAP;
        gap_cnt_d = GCW'(GAP_CYC);
      end
      GAP: begin
        if (gap_cnt_q == GCW'(1)) state_d = IDLE;
        else                      gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs; reset aborts any frame and drops the lane at once.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      par_q        <= 1'b0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ptr_q        <= '0;
      GNT_ID       <= '0;
      PREIO_OUT    <= IDLE_LVL;
      PREIO_CLK_EN <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ptr_q        <= ptr_d;
      GNT_ID       <= gnt_id_d;
      PREIO_OUT    <= lane_d;
      PREIO_CLK_EN <= clk_en_d;
      BUSY         <= busy_d;
    end
  end

endmodule

// File: tb/tb_preio_serial_arbiter.sv
// Self-checking bench for preio_serial_arbiter against a frame-level reference model.
module tb_preio_serial_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int GAP_CYC = 2;
  localparam int GW      = 2;
  localparam int FRAME   = 2 + DW + GAP_CYC;

  logic          FPGA_CLK   = 1'b0;
  logic          FPGA_RST_N = 1'b0;
  logic          ENABLE     = 1'b0;
  logic          PREIO_OUT;
  logic          PREIO_CLK_EN;
  logic          BUSY;
  logic [GW-1:0] GNT_ID;

  preio_serial_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  preio_serial_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP_CYC)) dut (
    .FPGA_CLK     (FPGA_CLK),
    .FPGA_RST_N   (FPGA_RST_N),
    .ENABLE       (ENABLE),
    .req          (bus),
    .PREIO_OUT    (PREIO_OUT),
    .PREIO_CLK_EN (PREIO_CLK_EN),
    .BUSY         (BUSY),
    .GNT_ID       (GNT_ID)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  int n_tests   = 0;
  int n_fail    = 0;
  int model_ptr = 0;
  logic [DW-1:0] words [NREQ];

  task automatic step();
    @(posedge FPGA_CLK);
    #2;
  endtask

  task automatic load_words();
    for (int i = 0; i < NREQ; i++) bus.REQ_DATA[i*DW +: DW] = words[i];
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  // Lane value k cycles after the accept edge: start, LSB-first data, even parity, gap zeros.
  function automatic logic exp_lane(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b1;
    if (k <= DW) return w[k-1];
    if (k == DW + 1) return ^w;
    return 1'b0;
  endfunction

  // Expects requester w to win in the current IDLE cycle, then follows its whole frame.
  // en_mode: 0 leave ENABLE, 1 drop ENABLE during DATA and leave it low, 2 toggle randomly.
  task automatic run_frame(input int w, input logic [DW-1:0] word,
                           input logic [NREQ-1:0] valid_after, input int en_mode,
                           input string name);
    logic [NREQ-1:0] exp_ready;
    exp_ready    = '0;
    exp_ready[w] = 1'b1;
    #1;
    n_tests++;
    if (bus.REQ_READY !== exp_ready) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want %b", name, bus.REQ_READY, exp_ready);
    end
    step();
    model_ptr = (w + 1) % NREQ;
    for (int k = 0; k < FRAME; k++) begin
      n_tests++;
      if (PREIO_OUT !== exp_lane(word, k)) begin
        n_fail++;
        $display("FAIL %s lane k=%0d: got %b want %b", name, k, PREIO_OUT, exp_lane(word, k));
      end
      n_tests++;
      if (PREIO_CLK_EN !== (k <= DW + 1) || BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL %s clk_en/busy k=%0d: got %b/%b want %b/1", name, k, PREIO_CLK_EN,
                 BUSY, (k <= DW + 1));
      end
      n_tests++;
      if (bus.REQ_READY !== '0 || GNT_ID !== GW'(w)) begin
        n_fail++;
        $display("FAIL %s ready/gnt k=%0d: got %b/%0d want 0000/%0d", name, k, bus.REQ_READY,
                 GNT_ID, w);
      end
      if (en_mode == 1 && k == 3) ENABLE = 1'b0;
      if (en_mode == 2) ENABLE = 1'($urandom_range(0, 1));
      if (k == FRAME - 1) begin
        bus.REQ_VALID = valid_after;
        if (en_mode == 2) ENABLE = 1'b1;
      end
      step();
    end
    n_tests++;
    if (BUSY !== 1'b0 || PREIO_OUT !== 1'b0 || PREIO_CLK_EN !== 1'b0 || GNT_ID !== GW'(w)) begin
      n_fail++;
      $display("FAIL %s idle_after: got busy=%b lane=%b clk_en=%b gnt=%0d want 0/0/0/%0d",
               name, BUSY, PREIO_OUT, PREIO_CLK_EN, GNT_ID, w);
    end
  endtask

  task automatic do_reset();
    FPGA_RST_N = 1'b0;
    step();
    step();
    FPGA_RST_N = 1'b1;
    model_ptr  = 0;
    step();
  endtask

  task automatic test_reset();
    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;
    ENABLE        = 1'b1;
    FPGA_RST_N    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (PREIO_OUT !== 1'b0 || BUSY !== 1'b0 || bus.REQ_READY !== '0 ||
          PREIO_CLK_EN !== 1'b0 || GNT_ID !== '0) begin
        n_fail++;
        $display("FAIL reset c=%0d: got lane=%b busy=%b ready=%b clk_en=%b gnt=%0d want all 0",
                 c, PREIO_OUT, BUSY, bus.REQ_READY, PREIO_CLK_EN, GNT_ID);
      end
    end
    FPGA_RST_N = 1'b1;
    model_ptr  = 0;
    step();
    n_tests++;
    if (BUSY !== 1'b0 || bus.REQ_READY !== '0 || PREIO_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b ready=%b lane=%b want 0/0000/0", BUSY,
               bus.REQ_READY, PREIO_OUT);
    end
  endtask

  task automatic test_single_frame();
    words[1] = 8'hA5;
    load_words();
    ENABLE        = 1'b1;
    bus.REQ_VALID = 4'b0010;
    run_frame(model_winner(4'b0010, model_ptr), 8'hA5, 4'b0000, 0, "single_a5");
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    for (int i = 0; i < NREQ; i++) words[i] = 8'($urandom);
    load_words();
    ENABLE        = 1'b1;
    bus.REQ_VALID = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      w = model_winner(4'b1111, model_ptr);
      run_frame(w, words[w], (n == 4) ? 4'b0000 : 4'b1111, 0, $sformatf("rr%0d", n));
    end
  endtask

  task automatic test_enable();
    words[2] = 8'($urandom);
    load_words();
    ENABLE        = 1'b0;
    bus.REQ_VALID = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (bus.REQ_READY !== '0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_block c=%0d: got ready=%b busy=%b want 0000/0", c,
                 bus.REQ_READY, BUSY);
      end
      step();
    end
    ENABLE = 1'b1;
    run_frame(model_winner(4'b0100, model_ptr), words[2], 4'b0100, 1, "enable_mid");
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (bus.REQ_READY !== '0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_after c=%0d: got ready=%b busy=%b want 0000/0", c,
                 bus.REQ_READY, BUSY);
      end
      step();
    end
    bus.REQ_VALID = '0;
    ENABLE        = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    words[1] = 8'h5B;
    words[3] = 8'($urandom);
    load_words();
    bus.REQ_VALID = 4'b0010;
    #1;
    n_tests++;
    if (bus.REQ_READY !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_mid ready: got %b want 0010", bus.REQ_READY);
    end
    step();
    for (int k = 0; k <= 5; k++) begin
      n_tests++;
      if (PREIO_OUT !== exp_lane(words[1], k)) begin
        n_fail++;
        $display("FAIL rst_mid lane k=%0d: got %b want %b", k, PREIO_OUT, exp_lane(words[1], k));
      end
      if (k < 5) step();
    end
    #2;
    FPGA_RST_N = 1'b0;
    #1;
    n_tests++;
    if (PREIO_OUT !== 1'b0 || BUSY !== 1'b0 || PREIO_CLK_EN !== 1'b0 ||
        bus.REQ_READY !== '0 || GNT_ID !== '0) begin
      n_fail++;
      $display("FAIL rst_mid async: got lane=%b busy=%b clk_en=%b ready=%b gnt=%0d want all 0",
               PREIO_OUT, BUSY, PREIO_CLK_EN, bus.REQ_READY, GNT_ID);
    end
    step();
    step();
    FPGA_RST_N    = 1'b1;
    model_ptr     = 0;
    bus.REQ_VALID = 4'b1010;
    run_frame(model_winner(4'b1010, model_ptr), words[1], 4'b1000, 0, "rst_resend");
    run_frame(model_winner(4'b1000, model_ptr), words[3], 4'b0000, 0, "rst_next");
  endtask

  task automatic test_drop_valid();
    for (int i = 0; i < NREQ; i++) words[i] = 8'($urandom);
    load_words();
    bus.REQ_VALID = 4'b1100;
    run_frame(model_winner(4'b1100, model_ptr), words[2], 4'b0001, 0, "drop_setup");
    run_frame(model_winner(4'b0001, model_ptr), words[0], 4'b0000, 0, "drop_valid");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] v;
    int w;
    for (int n = 0; n < 20; n++) begin
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) words[i] = 8'($urandom);
      load_words();
      bus.REQ_VALID = v;
      if ($urandom_range(0, 3) == 0) begin
        ENABLE = 1'b0;
        #1;
        n_tests++;
        if (bus.REQ_READY !== '0) begin
          n_fail++;
          $display("FAIL rand%0d disabled_ready: got %b want 0000", n, bus.REQ_READY);
        end
        step();
        n_tests++;
        if (BUSY !== 1'b0) begin
          n_fail++;
          $display("FAIL rand%0d disabled_busy: got %b want 0", n, BUSY);
        end
      end
      ENABLE = 1'b1;
      w = model_winner(v, model_ptr);
      run_frame(w, words[w], 4'b0000, 2, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_enable();
    test_reset_mid_frame();
    test_drop_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
